// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// Bytes are captured on the receiver's one-cycle data-valid strobe. The oldest byte is
// presented first-word-fall-through and removed with a pop request. A sticky flag
// records any byte dropped because the buffer was full.
module uart_rx_fifo #(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned NB_ADDR = $clog2(DEPTH)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_data_valid,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_read,
   input  logic               i_clear_overrun,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_empty,
   output logic               o_full,
   output logic [NB_ADDR:0]   o_count,
   output logic               o_overrun
);

   localparam logic [NB_ADDR:0] CountFull = (NB_ADDR + 1)'(DEPTH);

   logic [NB_DATA-1:0] mem_q [DEPTH];
   logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
   logic [NB_ADDR:0]   count_q, count_d;
   logic               overrun_q, overrun_d;

   logic empty, full;
   logic rd_acc, wr_acc, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CountFull);

   // A full FIFO still accepts a write when a pop frees the head slot in the same cycle.
   assign rd_acc = i_read & ~empty;
   assign wr_acc = i_data_valid & (~full | rd_acc);
   assign drop   = i_data_valid & full & ~rd_acc;

   // Next-state for pointers, occupancy and the sticky overrun flag.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + NB_ADDR'(1);
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (NB_ADDR + 1)'(1);
         2'b01:   count_d = count_q - (NB_ADDR + 1)'(1);
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (i_clear_overrun) begin
         overrun_d = 1'b0;
      end
   end

   // Control state with synchronous reset that overrides any concurrent traffic.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Byte storage; contents are not reset, the count alone marks them valid.
   always_ff @(posedge i_clock) begin
      if (wr_acc && !i_reset) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // Outputs depend only on registered state.
   always_comb begin
      o_data    = empty ? '0 : mem_q[rd_ptr_q];
      o_empty   = empty;
      o_full    = full;
      o_count   = count_q;
      o_overrun = overrun_q;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes accepted bytes into an expected
// queue, a negedge monitor checks flags against a count model and pops on handshakes.
module tb_uart_rx_fifo;

   localparam int NbData = 8;
   localparam int Depth  = 16;
   localparam int NbAddr = $clog2(Depth);

   logic              clk;
   logic              rst;
   logic              dv;
   logic [NbData-1:0] din;
   logic              rd;
   logic              clr;
   logic [NbData-1:0] dout;
   logic              empty;
   logic              full;
   logic [NbAddr:0]   count;
   logic              ovr;

   uart_rx_fifo #(
      .NB_DATA (NbData),
      .DEPTH   (Depth),
      .NB_ADDR (NbAddr)
   ) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_data_valid    (dv),
      .i_data          (din),
      .i_read          (rd),
      .i_clear_overrun (clr),
      .o_data          (dout),
      .o_empty         (empty),
      .o_full          (full),
      .o_count         (count),
      .o_overrun       (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of bytes stored in order, occupancy and sticky flag.
   logic [NbData-1:0] sb_q[$];
   int                m_count;
   bit                m_ovr;
   bit                mon_en;
   int                errors;
   int                checks;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: DUT outputs are stable at negedge and reflect state after the last edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("count", int'(count), m_count);
         check("empty", int'(empty), int'(m_count == 0));
         check("full", int'(full), int'(m_count == Depth));
         check("overrun", int'(ovr), int'(m_ovr));
         if (m_count == 0) begin
            check("data_when_empty", int'(dout), 0);
         end
         if (rd && !empty && !rst) begin
            if (sb_q.size() == 0) begin
               check("pop_with_no_expected_byte", 1, 0);
            end else begin
               check("pop_data", int'(dout), int'(sb_q[0]));
               void'(sb_q.pop_front());
            end
         end
      end
   end

   // One clock cycle: drive inputs, record expected acceptance, advance model after the edge.
   task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit c, input bit s);
      bit rd_acc, wr_acc, drop;
      dv  = v;
      din = d;
      rd  = r;
      clr = c;
      rst = s;
      rd_acc = r && (m_count > 0);
      wr_acc = v && ((m_count < Depth) || rd_acc);
      drop   = v && (m_count == Depth) && !rd_acc;
      if (wr_acc && !s) sb_q.push_back(d);
      @(posedge clk);
      #1;
      if (s) begin
         m_count = 0;
         m_ovr   = 1'b0;
         sb_q.delete();
      end else begin
         m_count = m_count + int'(wr_acc) - int'(rd_acc);
         if (drop) m_ovr = 1'b1;
         else if (c) m_ovr = 1'b0;
      end
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      mon_en  = 1'b0;
      m_count = 0;
      m_ovr   = 1'b0;
      dv = 1'b0; din = '0; rd = 1'b0; clr = 1'b0; rst = 1'b1;

      // Reset held two cycles while a write strobe is present.
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      idle();
      check("reset_data", int'(dout), 0);

      // Ordering and empty pops.
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      check("order_head", int'(dout), 8'hA5);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();

      // Overflow: fill, drop one, drain, clear.
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      check("overflow_flag", int'(ovr), 1);
      for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle();

      // Full with simultaneous write and read, then set-vs-clear priority.
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
      check("set_beats_clear", int'(ovr), 1);
      for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Empty with simultaneous write and read.
      cycle(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
      check("empty_wr_rd_data", int'(dout), 8'h42);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();

      // Streaming across pointer wrap with pops lagging by three.
      for (int k = 0; k < 43; k++) begin
         cycle(k < 40, 8'(8'h10 + k), k >= 3, 1'b0, 1'b0);
      end
      idle();

      // Mid-stream reset then reuse.
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("midreset_count", int'(count), 0);
      cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
      check("after_reset_data", int'(dout), 8'hE1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();

      // Randomized traffic with phases of different read/write bias.
      for (int ph = 0; ph < 8; ph++) begin
         int wp, rp;
         wp = (ph % 2 == 0) ? 80 : 30;
         rp = (ph % 2 == 0) ? 30 : 80;
         for (int i = 0; i < 250; i++) begin
            cycle($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
                  $urandom_range(99) < 5, $urandom_range(299) == 0);
         end
      end
      for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
